jtopl_slot_inject: RTL and testbench



---
 rtl/jtopl_pkg.sv | 9 +
 rtl/jtopl_slot_cnt.sv | 38 +++
 rtl/jtopl_slot_inject.sv | 114 +++++++++++
 tb/tb_jtopl_slot_inject.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// Shared constants for the per-slot operator pipeline stages.
// The defaults match the 18-slot OPL rotation.
package jtopl_pkg;

  localparam int JTOPL_SLOTS = 18;
  localparam int JTOPL_SW    = 5;
  localparam int JTOPL_WIDTH = 5;

endpackage

// File: rtl/jtopl_slot_cnt.sv
// Wrapping slot rotation counter with clock enable and a slot-zero flag.
// Shared by any stage that needs to know which slot is on the bus.
module jtopl_slot_cnt
  import jtopl_pkg::*;
#(
  parameter int STAGES = JTOPL_SLOTS,
  parameter int SW     = JTOPL_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [SW-1:0] slot,
  output logic          zero
);

  localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

  logic [SW-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (cen) begin
      slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign zero = (slot_q == '0);

endmodule

// File: rtl/jtopl_slot_inject.sv
// Injects one CPU register write into a per-slot delay line, substituting
// the held value for the recirculated one when the rotation reaches its slot.
module jtopl_slot_inject
  import jtopl_pkg::*;
#(
  parameter int WIDTH  = JTOPL_WIDTH,
  parameter int STAGES = JTOPL_SLOTS,
  parameter int SW     = JTOPL_SW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [SW-1:0]    wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_done,
  output logic             wr_err,
  input  logic [WIDTH-1:0] fb_in,
  output logic [WIDTH-1:0] dout,
  output logic [SW-1:0]    slot,
  output logic             zero
);

  // state   | meaning
  // ST_IDLE | nothing held, wr_ready high, dout recirculates fb_in
  // ST_PEND | one write held until the rotation reaches pslot
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // One extra bit so the range check also works when 2^SW == STAGES.
  localparam logic [SW:0] NSLOT = (SW + 1)'(STAGES);

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    pslot_q, pslot_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [SW-1:0]    slot_w;
  logic             in_range;
  logic             hit;
  logic             commit;

  jtopl_slot_cnt #(
    .STAGES (STAGES),
    .SW     (SW)
  ) u_slot_cnt (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .slot (slot_w),
    .zero (zero)
  );

  assign in_range = ({1'b0, wr_slot} < NSLOT);
  assign hit      = (state_q == ST_PEND) && (pslot_q == slot_w);
  assign commit   = cen && hit;

  // Accepting only from ST_IDLE means the accepting edge can never also
  // commit, so a same-slot write waits a full rotation.
  always_comb begin
    state_d = state_q;
    pslot_d = pslot_q;
    pdata_d = pdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          if (in_range) begin
            state_d = ST_PEND;
            pslot_d = wr_slot;
            pdata_d = wr_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (commit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pslot_q <= '0;
      pdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pslot_q <= pslot_d;
      pdata_q <= pdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_ready = (state_q == ST_IDLE);
  assign wr_done  = done_q;
  assign wr_err   = err_q;
  assign slot     = slot_w;
  assign dout     = hit ? pdata_q : fb_in;

endmodule

// File: tb/tb_jtopl_slot_inject.sv
// Directed bench for jtopl_slot_inject with an 18-deep delay line closing the loop
// and a tick-distance model of the pending write checked every cycle.
module tb_jtopl_slot_inject;

  localparam int N = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_slot;
  logic [4:0] wr_data;
  logic       wr_done;
  logic       wr_err;
  logic [4:0] fb_in;
  logic [4:0] dout;
  logic [4:0] slot;
  logic       zero;

  logic [4:0] dl [N];
  logic       dl_load;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtopl_slot_inject #(
    .WIDTH  (5),
    .STAGES (N),
    .SW     (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_slot  (wr_slot),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .fb_in    (fb_in),
    .dout     (dout),
    .slot     (slot),
    .zero     (zero)
  );

  // External delay line: what goes in on a cen edge comes out N cen edges later.
  always @(posedge clk) begin
    if (dl_load) begin
      for (int i = 0; i < N; i++) dl[i] <= 5'h0A;
    end else if (cen) begin
      dl[0] <= dout;
      for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
    end
  end
  assign fb_in = dl[N-1];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < 40; i++) begin
      if (int'(slot) == s) break;
      tick();
    end
    chk("wait_slot", int'(slot), s);
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (wr_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Model: slot as a tick count mod N; a pending write as "cen ticks left until commit".
  initial begin
    int m_slot, m_left, m_pdata, m_pend, m_done, m_err, p0, sp, exp_dout;
    m_slot = 0; m_left = 0; m_pdata = 0; m_pend = 0; m_done = 0; m_err = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        m_slot = 0; m_left = 0; m_pdata = 0; m_pend = 0; m_done = 0; m_err = 0;
      end
      exp_dout = (m_pend != 0 && m_left == 1) ? m_pdata : int'(fb_in);
      chk("slot", int'(slot), m_slot);
      chk("zero", int'(zero), int'(m_slot == 0));
      chk("wr_ready", int'(wr_ready), int'(m_pend == 0));
      chk("wr_done", int'(wr_done), m_done);
      chk("wr_err", int'(wr_err), m_err);
      chk("dout", int'(dout), exp_dout);
      if (rst === 1'b1) begin
        p0 = m_pend;
        m_done = 0;
        m_err = 0;
        if (m_pend != 0 && cen) begin
          if (m_left == 1) begin
            m_pend = 0;
            m_done = 1;
          end else begin
            m_left--;
          end
        end
        sp = cen ? (m_slot + 1) % N : m_slot;
        if (p0 == 0 && wr_valid) begin
          if (int'(wr_slot) < N) begin
            m_pend = 1;
            m_pdata = int'(wr_data);
            m_left = ((int'(wr_slot) - sp) % N + N) % N + 1;
          end else begin
            m_err = 1;
          end
        end
        m_slot = sp;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, cnt, cnt2;
    rst = 1'b0; cen = 1'b1; wr_valid = 1'b0; wr_slot = '0; wr_data = '0; dl_load = 1'b1;
    repeat (3) tick();
    dl_load = 1'b0;
    rst = 1'b1;

    // 1: free-running rotation, no writes
    chk("t1_slot0", int'(slot), 0);
    chk("t1_dout", int'(dout), 'h0A);
    cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (zero) cnt++;
    end
    chk("t1_zero_count", cnt, 2);
    chk("t1_ready", int'(wr_ready), 1);

    // 2: write slot 5 accepted at slot 2
    wait_slot(2);
    wr_valid = 1'b1; wr_slot = 5'd5; wr_data = 5'h1F;
    tick();
    wr_valid = 1'b0;
    chk("t2_ready_low", int'(wr_ready), 0);
    wait_done(25, c);
    chk("t2_done_latency", c, 3);
    chk("t2_slot_after", int'(slot), 6);
    wait_slot(5);
    chk("t2_fb_recirc", int'(fb_in), 'h1F);
    chk("t2_dout_recirc", int'(dout), 'h1F);

    // 3: same-slot write waits a full rotation
    wait_slot(7);
    wr_valid = 1'b1; wr_slot = 5'd7; wr_data = 5'h03;
    tick();
    wr_valid = 1'b0;
    wait_done(25, c);
    chk("t3_done_latency", c, 18);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wr_done) cnt++;
    end
    chk("t3_single_done", cnt, 0);

    // 4: back-pressure plus gated cen
    wait_slot(10);
    wr_valid = 1'b1; wr_slot = 5'd12; wr_data = 5'h11;
    tick();
    wr_slot = 5'd3; wr_data = 5'h07;
    cen = 1'b0;
    chk("t4_ready_low", int'(wr_ready), 0);
    chk("t4_slot_at_gate", int'(slot), 11);
    repeat (10) tick();
    chk("t4_slot_frozen", int'(slot), 11);
    chk("t4_still_pending", int'(wr_ready), 0);
    cen = 1'b1;
    wait_done(30, c);
    chk("t4_first_latency", c, 2);
    chk("t4_ready_with_done", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    chk("t4_second_taken", int'(wr_ready), 0);
    wait_done(30, c);
    chk("t4_second_latency", c, 8);

    // 5: out-of-range slots are rejected
    tick();
    wr_valid = 1'b1; wr_slot = 5'd18; wr_data = 5'h1E;
    tick();
    chk("t5_err18", int'(wr_err), 1);
    chk("t5_ready18", int'(wr_ready), 1);
    wr_slot = 5'd31;
    tick();
    wr_valid = 1'b0;
    chk("t5_err31", int'(wr_err), 1);
    tick();
    chk("t5_err_clear", int'(wr_err), 0);

    // 6: reset while a write is pending discards it
    wait_slot(0);
    wr_valid = 1'b1; wr_slot = 5'd16; wr_data = 5'h15;
    tick();
    wr_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("t6_slot_reset", int'(slot), 0);
    chk("t6_ready_reset", int'(wr_ready), 1);
    chk("t6_zero_reset", int'(zero), 1);
    repeat (2) tick();
    rst = 1'b1;
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (wr_done) cnt++;
      if (dout == 5'h15) cnt2++;
    end
    chk("t6_no_done", cnt, 0);
    chk("t6_no_value", cnt2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
